// File: rtl/fp_add_result_queue.sv
// Result queue behind the pipelined fp_adder: tracks issues through the adder
// latency, substitutes zero/cancellation results and saturates overflow.
module fp_add_result_queue #(
    parameter int LAT   = 5,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    input  logic [31:0]   adder_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          out_fix,
    output logic          out_ovf,
    output logic [CW-1:0] occ
);
    localparam int AW = $clog2(DEPTH);

    logic [LAT-1:0] vld_q, vld_d;
    logic [LAT-1:0] fix_q, fix_d;
    logic [31:0]    fv_q [LAT];
    logic [31:0]    fv_d [LAT];

    logic [33:0]    mem_q [DEPTH];
    logic [33:0]    mem_d [DEPTH];
    logic [AW:0]    wp_q, wp_d;
    logic [AW:0]    rp_q, rp_d;
    logic [CW-1:0]  occ_q, occ_d;

    logic        issue, pop, wr_en, empty, full;
    logic        cls_fix;
    logic [31:0] cls_val;
    logic [33:0] wr_word;

    assign in_ready = (occ_q < CW'(DEPTH));
    assign issue    = in_valid && in_ready;
    assign empty    = (wp_q == rp_q);
    assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign out_valid = !empty;
    assign pop      = out_valid && out_ready;
    assign wr_en    = vld_q[LAT-1];
    assign occ      = occ_q;

    assign out_data = mem_q[rp_q[AW-1:0]][33:2];
    assign out_fix  = mem_q[rp_q[AW-1:0]][1];
    assign out_ovf  = mem_q[rp_q[AW-1:0]][0];

    // Cases the adder cannot handle: zero operands and exact cancellation
    always_comb begin
        cls_fix = 1'b1;
        cls_val = 32'h0000_0000;
        if (in_a[30:0] == 31'd0 && in_b[30:0] == 31'd0) begin
            cls_val = {in_a[31] & in_b[31], 31'd0};
        end else if (in_a[30:0] == 31'd0) begin
            cls_val = in_b;
        end else if (in_b[30:0] == 31'd0) begin
            cls_val = in_a;
        end else if (in_a[30:0] == in_b[30:0] && in_a[31] != in_b[31]) begin
            cls_val = 32'h0000_0000;
        end else begin
            cls_fix = 1'b0;
        end
    end

    always_comb begin
        vld_d    = {vld_q[LAT-2:0], issue};
        fix_d    = {fix_q[LAT-2:0], cls_fix};
        fv_d[0]  = cls_val;
        for (int i = 1; i < LAT; i++) begin
            fv_d[i] = fv_q[i-1];
        end
    end

    always_comb begin
        if (fix_q[LAT-1]) begin
            wr_word = {fv_q[LAT-1], 1'b1, 1'b0};
        end else if (adder_out[30:23] == 8'hFF) begin
            wr_word = {adder_out[31], 8'hFF, 23'd0, 1'b0, 1'b1};
        end else begin
            wr_word = {adder_out, 2'b00};
        end
    end

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (wr_en) begin
            mem_d[wp_q[AW-1:0]] = wr_word;
            wp_d = wp_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rp_d = rp_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_comb begin
        case ({issue, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            fix_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                fv_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            occ_q <= '0;
        end else begin
            vld_q <= vld_d;
            fix_q <= fix_d;
            fv_q  <= fv_d;
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
        end
    end

    // Credits bound outstanding work to DEPTH, so a write can never hit a full queue
    a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule
